// File: rtl/dbus_loader.sv
// Host byte-stream to dBus bridge: decodes write-block / read-block frames into
// 32-bit word commands and returns read data or a write acknowledge byte.
module dbus_loader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        dbus_cmd_valid,
    input  logic        dbus_cmd_ready,
    output logic        dbus_cmd_wr,
    output logic [31:0] dbus_cmd_address,
    output logic [31:0] dbus_cmd_data,
    output logic [1:0]  dbus_cmd_size,
    input  logic        dbus_rsp_ready,
    input  logic [31:0] dbus_rsp_data,
    output logic        busy,
    output logic        bad_opcode
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 9;

    localparam logic [7:0] ACK_BYTE = 8'h4B;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_WDATA,
        S_WCMD,
        S_RCMD,
        S_RWAIT,
        S_RDATA,
        S_ACK
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          byte_q, byte_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic                wr_q, wr_d;
    logic                bad_q, bad_d;

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                busy_q, busy_d;

    logic                in_fire;
    logic                out_fire;
    logic                cmd_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign cmd_fire = cmd_valid_q && dbus_cmd_ready;

    // Frame decode and word sequencing
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        byte_d  = byte_q;
        words_d = words_q;
        wr_d    = wr_q;
        bad_d   = bad_q;

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    byte_d = 2'd0;
                    if (in_data == OP_WRITE || in_data == OP_READ) begin
                        wr_d    = (in_data == OP_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (in_fire) begin
                    addr_d[{byte_q, 3'b000} +: 8] = in_data;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = S_CNT;
                    end
                end
            end
            S_CNT: begin
                if (in_fire) begin
                    words_d = CNT_W'(in_data) + CNT_W'(1);
                    byte_d  = 2'd0;
                    state_d = wr_q ? S_WDATA : S_RCMD;
                end
            end
            S_WDATA: begin
                if (in_fire) begin
                    data_d[{byte_q, 3'b000} +: 8] = in_data;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = S_WCMD;
                    end
                end
            end
            S_WCMD: begin
                if (cmd_fire) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    words_d = words_q - CNT_W'(1);
                    state_d = (words_q == CNT_W'(1)) ? S_ACK : S_WDATA;
                end
            end
            S_RCMD: begin
                if (cmd_fire) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    words_d = words_q - CNT_W'(1);
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (dbus_rsp_ready) begin
                    data_d  = dbus_rsp_data;
                    byte_d  = 2'd0;
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (out_fire) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = (words_q == CNT_W'(0)) ? S_IDLE : S_RCMD;
                    end
                end
            end
            S_ACK: begin
                if (out_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Word alignment: the low address bits are never driven
        addr_d[1:0] = 2'b00;
    end

    // Output flops are loaded from the next state so they line up with it
    always_comb begin
        in_ready_d  = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                      (state_d == S_CNT)  || (state_d == S_WDATA);
        out_valid_d = (state_d == S_RDATA) || (state_d == S_ACK);
        cmd_valid_d = (state_d == S_WCMD) || (state_d == S_RCMD);
        busy_d      = (state_d != S_IDLE);
        out_data_d  = 8'h00;
        if (state_d == S_ACK) begin
            out_data_d = ACK_BYTE;
        end else if (state_d == S_RDATA) begin
            out_data_d = data_d[{byte_d, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            byte_q      <= '0;
            words_q     <= '0;
            wr_q        <= 1'b0;
            bad_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            byte_q      <= byte_d;
            words_q     <= words_d;
            wr_q        <= wr_d;
            bad_q       <= bad_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign dbus_cmd_valid   = cmd_valid_q;
    assign dbus_cmd_wr      = wr_q;
    assign dbus_cmd_address = addr_q;
    assign dbus_cmd_data    = data_q;
    assign dbus_cmd_size    = 2'd2;
    assign busy             = busy_q;
    assign bad_opcode       = bad_q;

endmodule

// File: tb/tb_dbus_loader.sv
// Directed bench for dbus_loader: frame table plus hand-written stall, wrap,
// backpressure and mid-frame reset sequences against a small RAM model.
module tb_dbus_loader;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        dbus_cmd_valid;
    logic        dbus_cmd_ready;
    logic        dbus_cmd_wr;
    logic [31:0] dbus_cmd_address;
    logic [31:0] dbus_cmd_data;
    logic [1:0]  dbus_cmd_size;
    logic        dbus_rsp_ready;
    logic [31:0] dbus_rsp_data;
    logic        busy;
    logic        bad_opcode;

    dbus_loader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .dbus_cmd_valid   (dbus_cmd_valid),
        .dbus_cmd_ready   (dbus_cmd_ready),
        .dbus_cmd_wr      (dbus_cmd_wr),
        .dbus_cmd_address (dbus_cmd_address),
        .dbus_cmd_data    (dbus_cmd_data),
        .dbus_cmd_size    (dbus_cmd_size),
        .dbus_rsp_ready   (dbus_rsp_ready),
        .dbus_rsp_data    (dbus_rsp_data),
        .busy             (busy),
        .bad_opcode       (bad_opcode)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } cmd_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_bad;
        int          exp_cmds;
        logic [31:0] exp_addr;
        logic [31:0] exp_out;
        int          exp_nout;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    bit          stall_mode = 0;
    bit          out_toggle = 0;
    bit          gaps = 0;
    cmd_t        cmdq[$];
    logic [7:0]  outq[$];
    logic [31:0] wq[$];
    logic [31:0] mem [logic [31:0]];

    // responder state
    int          stall_cnt = 0;
    bit          rsp_pend = 0;
    logic [31:0] rsp_word = '0;
    bit          cmd_held = 0;
    cmd_t        cmd_prev;
    cmd_t        cmd_cur;
    bit          out_held = 0;
    logic [7:0]  out_prev = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // dBus RAM model: ready policy, one-cycle read response, stall stability
    initial begin
        dbus_cmd_ready = 1'b1;
        dbus_rsp_ready = 1'b0;
        dbus_rsp_data  = '0;
        forever begin
            @(negedge clk);
            dbus_rsp_ready = rsp_pend;
            dbus_rsp_data  = rsp_word;
            rsp_pend       = 0;
            dbus_cmd_ready = !stall_mode || (stall_cnt >= 5);
            if (dbus_cmd_valid) begin
                cmd_cur = {dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size};
                if (cmd_held) begin
                    chk("stall_addr", cmd_cur.addr, cmd_prev.addr);
                    chk("stall_data", cmd_cur.data, cmd_prev.data);
                    chk("stall_wr", 32'(cmd_cur.wr), 32'(cmd_prev.wr));
                end
                if (dbus_cmd_ready) begin
                    cmdq.push_back(cmd_cur);
                    if (cmd_cur.wr) begin
                        mem[cmd_cur.addr] = cmd_cur.data;
                    end else begin
                        rsp_pend = 1;
                        rsp_word = mem.exists(cmd_cur.addr) ? mem[cmd_cur.addr] : 32'h0;
                    end
                    stall_cnt = 0;
                    cmd_held  = 0;
                end else begin
                    stall_cnt++;
                    cmd_held = 1;
                    cmd_prev = cmd_cur;
                end
            end else begin
                cmd_held = 0;
            end
        end
    end

    // Output byte sink with optional every-other-cycle backpressure
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = out_toggle ? !out_ready : 1'b1;
            if (out_valid) begin
                if (out_held) chk("out_stable", 32'(out_data), 32'(out_prev));
                if (out_ready) begin
                    outq.push_back(out_data);
                    out_held = 0;
                end else begin
                    out_held = 1;
                    out_prev = out_data;
                end
            end else begin
                out_held = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [7:0] cnt);
        send_byte(op);
        if (op == 8'h57 || op == 8'h52) begin
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
            send_byte(cnt);
            if (op == 8'h57) begin
                for (int w = 0; w < wq.size(); w++)
                    for (int i = 0; i < 4; i++) send_byte(wq[w][8*i +: 8]);
            end
        end
    endtask

    task automatic wait_done(input int nout);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while ((busy || outq.size() < nout) && t < 3000);
        if (t >= 3000) begin
            chk("timeout_busy", 32'(busy), 32'd0);
            chk("timeout_nout", 32'(outq.size()), 32'(nout));
        end
    endtask

    function automatic logic [31:0] out_word(input int idx);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (idx * 4 + i < outq.size()) w[8*i +: 8] = outq[idx * 4 + i];
        return w;
    endfunction

    task automatic clear_logs();
        cmdq.delete();
        outq.delete();
        wq.delete();
    endtask

    initial begin
        vec_t vecs[8];
        int   t;
        vecs[0] = '{8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1, 32'h0000_0100, 32'h0000_004B, 1};
        vecs[1] = '{8'h57, 32'h0000_0107, 32'h1234_5678, 1'b0, 1, 32'h0000_0104, 32'h0000_004B, 1};
        vecs[2] = '{8'h52, 32'h0000_0100, 32'h0,         1'b0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4};
        vecs[3] = '{8'h52, 32'h0000_0106, 32'h0,         1'b0, 1, 32'h0000_0104, 32'h1234_5678, 4};
        vecs[4] = '{8'h41, 32'h0,         32'h0,         1'b1, 0, 32'h0,         32'h0,         0};
        vecs[5] = '{8'h57, 32'h0000_0020, 32'hA5A5_0F0F, 1'b1, 1, 32'h0000_0020, 32'h0000_004B, 1};
        vecs[6] = '{8'h57, 32'hFFFF_FFFF, 32'h89AB_CDEF, 1'b1, 1, 32'hFFFF_FFFC, 32'h0000_004B, 1};
        vecs[7] = '{8'h52, 32'hFFFF_FFFD, 32'h0,         1'b1, 1, 32'hFFFF_FFFC, 32'h89AB_CDEF, 4};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_valid", 32'(dbus_cmd_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", dbus_cmd_address, 32'd0);
        chk("rst_bad", 32'(bad_opcode), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            clear_logs();
            wq.push_back(vecs[i].wdata);
            send_frame(vecs[i].op, vecs[i].addr, 8'h00);
            wait_done(vecs[i].exp_nout);
            chk($sformatf("v%0d_ncmd", i), 32'(cmdq.size()), 32'(vecs[i].exp_cmds));
            if (cmdq.size() > 0) begin
                chk($sformatf("v%0d_addr", i), cmdq[0].addr, vecs[i].exp_addr);
                chk($sformatf("v%0d_wr", i), 32'(cmdq[0].wr), 32'(vecs[i].op == 8'h57));
                chk($sformatf("v%0d_size", i), 32'(cmdq[0].size), 32'd2);
                if (vecs[i].op == 8'h57) chk($sformatf("v%0d_wdata", i), cmdq[0].data, vecs[i].wdata);
            end
            chk($sformatf("v%0d_nout", i), 32'(outq.size()), 32'(vecs[i].exp_nout));
            if (vecs[i].exp_nout > 0) chk($sformatf("v%0d_out", i), out_word(0), vecs[i].exp_out);
            chk($sformatf("v%0d_bad", i), 32'(bad_opcode), 32'(vecs[i].exp_bad));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // Two-word read; busy must fall right after the last byte
        clear_logs();
        send_frame(8'h52, 32'h0000_0100, 8'h01);
        t = 0;
        while (outq.size() < 8 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("A_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("A_busy_drop", 32'(busy), 32'd0);
        chk("A_ncmd", 32'(cmdq.size()), 32'd2);
        if (cmdq.size() == 2) begin
            chk("A_addr0", cmdq[0].addr, 32'h0000_0100);
            chk("A_addr1", cmdq[1].addr, 32'h0000_0104);
            chk("A_wr1", 32'(cmdq[1].wr), 32'd0);
        end
        chk("A_word0", out_word(0), 32'hDEAD_BEEF);
        chk("A_word1", out_word(1), 32'h1234_5678);

        // Three-word write with command stalls and input gaps
        clear_logs();
        stall_mode = 1;
        gaps = 1;
        wq.push_back(32'hA0B1_C2D3);
        wq.push_back(32'h1425_3647);
        wq.push_back(32'h5869_7A8B);
        send_frame(8'h57, 32'h0000_0200, 8'h02);
        wait_done(1);
        stall_mode = 0;
        gaps = 0;
        chk("B_ncmd", 32'(cmdq.size()), 32'd3);
        if (cmdq.size() == 3) begin
            chk("B_addr0", cmdq[0].addr, 32'h0000_0200);
            chk("B_addr1", cmdq[1].addr, 32'h0000_0204);
            chk("B_addr2", cmdq[2].addr, 32'h0000_0208);
            chk("B_data0", cmdq[0].data, 32'hA0B1_C2D3);
            chk("B_data1", cmdq[1].data, 32'h1425_3647);
            chk("B_data2", cmdq[2].data, 32'h5869_7A8B);
        end
        chk("B_nout", 32'(outq.size()), 32'd1);
        chk("B_ack", out_word(0), 32'h0000_004B);

        // Address wrap on a two-word read with output backpressure
        clear_logs();
        mem[32'h0000_0000] = 32'h0BAD_F00D;
        out_toggle = 1;
        send_frame(8'h52, 32'hFFFF_FFFE, 8'h01);
        wait_done(8);
        out_toggle = 0;
        chk("C_ncmd", 32'(cmdq.size()), 32'd2);
        if (cmdq.size() == 2) begin
            chk("C_addr0", cmdq[0].addr, 32'hFFFF_FFFC);
            chk("C_addr1", cmdq[1].addr, 32'h0000_0000);
        end
        chk("C_nout", 32'(outq.size()), 32'd8);
        chk("C_word0", out_word(0), 32'h89AB_CDEF);
        chk("C_word1", out_word(1), 32'h0BAD_F00D);

        // Reset mid-frame after two data bytes
        clear_logs();
        send_byte(8'h57);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        reset_n = 1'b0;
        #1;
        chk("D_in_ready", 32'(in_ready), 32'd0);
        chk("D_busy", 32'(busy), 32'd0);
        chk("D_cmd_valid", 32'(dbus_cmd_valid), 32'd0);
        chk("D_out_valid", 32'(out_valid), 32'd0);
        chk("D_addr", dbus_cmd_address, 32'd0);
        chk("D_cmd_data", dbus_cmd_data, 32'd0);
        chk("D_bad", 32'(bad_opcode), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("D_in_ready_after", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("D_no_cmd", 32'(cmdq.size()), 32'd0);
        wq.push_back(32'h4433_2211);
        send_frame(8'h57, 32'h0000_0300, 8'h00);
        wait_done(1);
        chk("D_ncmd", 32'(cmdq.size()), 32'd1);
        if (cmdq.size() == 1) begin
            chk("D_waddr", cmdq[0].addr, 32'h0000_0300);
            chk("D_wdata", cmdq[0].data, 32'h4433_2211);
        end
        chk("D_ack", out_word(0), 32'h0000_004B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
